// File: rtl/muldiv_seq.sv
// Iterative unsigned MUL/DIV sequencer: radix-2 shift-add multiply, radix-2 restoring divide.
// Optional MULDIV_EARLY_OUT_EN: MUL stops once no set multiplier bits remain.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    // hi/lo hold {acc, mplier} for MUL and {rem, quo} for DIV; opnd is mcand or divisor
    logic [WIDTH-1:0]   hi, lo, opnd;

    logic               accept, mul_last, ge;
    logic [WIDTH:0]     sum, rem_sh;
    logic [WIDTH-1:0]   mul_hi_n, mul_lo_n, div_hi_n, div_lo_n, rem_sub;
    logic [2*WIDTH-1:0] prod;

`ifdef MULDIV_EARLY_OUT_EN
    logic [WIDTH-2:0]   mrem;
`endif

    assign busy = (state == MUL) || (state == DIV);
    assign done = (state == DONE);

    always_comb begin
        accept   = start && ((state == IDLE) || (state == DONE));
        sum      = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        mul_hi_n = sum[WIDTH:1];
        mul_lo_n = {sum[0], lo[WIDTH-1:1]};
        rem_sh   = {hi, lo[WIDTH-1]};
        ge       = (rem_sh >= {1'b0, opnd});
        // when ge holds the true remainder is below the divisor, so the low WIDTH bits suffice
        rem_sub  = rem_sh[WIDTH-1:0] - opnd;
        div_hi_n = ge ? rem_sub : rem_sh[WIDTH-1:0];
        div_lo_n = {lo[WIDTH-2:0], ge};
`ifdef MULDIV_EARLY_OUT_EN
        // outstanding iterations would only shift in zeros, so apply them as one shift
        prod     = {mul_hi_n, mul_lo_n} >> (cnt - 1'b1);
        mul_last = (cnt == CW'(1)) || (mrem == '0);
`else
        prod     = {mul_hi_n, mul_lo_n};
        mul_last = (cnt == CW'(1));
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            opnd        <= '0;
            result      <= '0;
            result_hi   <= '0;
            div_by_zero <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
            mrem        <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (accept) begin
                        result      <= '0;
                        result_hi   <= '0;
                        div_by_zero <= 1'b0;
                        hi          <= '0;
                        opnd        <= op ? b : a;
                        lo          <= op ? a : b;
                        cnt         <= CW'(WIDTH);
`ifdef MULDIV_EARLY_OUT_EN
                        mrem        <= b[WIDTH-1:1];
`endif
                        if (op && (b == '0)) begin
                            state       <= DONE;
                            result      <= '1;
                            result_hi   <= a;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= op ? DIV : MUL;
                        end
                    end
                end
                MUL: begin
                    hi  <= mul_hi_n;
                    lo  <= mul_lo_n;
                    cnt <= cnt - 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
                    mrem <= mrem >> 1;
`endif
                    if (mul_last) begin
                        state     <= DONE;
                        result    <= prod[WIDTH-1:0];
                        result_hi <= prod[2*WIDTH-1:WIDTH];
                    end
                end
                DIV: begin
                    hi  <= div_hi_n;
                    lo  <= div_lo_n;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        result    <= div_lo_n;
                        result_hi <= div_hi_n;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
